// File: rtl/lamp_sequence_monitor.sv
// Receive-side checker for the crossing lamp lines: decodes the five lamp wires
// back into a phase code, filters transition glitches, measures per-phase dwell
// in ms ticks and latches sticky conflict / sequence / short-phase errors.
module lamp_sequence_monitor #(
   parameter int unsigned TICK_DIV      = 50000,
   parameter int unsigned STABLE_CYC    = 4,
   parameter int unsigned MIN_YELLOW_MS = 2000,
   parameter int unsigned MIN_PEDGRN_MS = 5000,
   parameter int unsigned MIN_REDYEL_MS = 1000,
   parameter int unsigned DWELL_W       = 16
) (
   input  logic               CLK_PCB,
   input  logic               nRST_PCB,
   input  logic               ROAD_RED,
   input  logic               ROAD_YELLOW,
   input  logic               ROAD_GREEN,
   input  logic               PED_RED,
   input  logic               PED_GREEN,
   input  logic               CLR_ERR,
   output logic [2:0]         STATE_CODE,
   output logic [DWELL_W-1:0] DWELL_MS,
   output logic               ERR_CONFLICT,
   output logic               ERR_SEQUENCE,
   output logic               ERR_SHORT,
   output logic [3:0]         LED
);

   typedef enum logic [2:0] {
      PH_UNKNOWN    = 3'd0,
      PH_GREEN      = 3'd1,
      PH_YELLOW     = 3'd2,
      PH_RED_PED    = 3'd3,
      PH_RED_YELLOW = 3'd4,
      PH_INVALID    = 3'd7
   } phase_t;

   localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned CNT_W = $clog2(STABLE_CYC + 1);

   localparam logic [PRE_W-1:0]   PRE_LAST  = PRE_W'(TICK_DIV - 1);
   localparam logic [CNT_W-1:0]   STABLE_N  = CNT_W'(STABLE_CYC);
   localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
   localparam logic [DWELL_W-1:0] MIN_Y     = DWELL_W'(MIN_YELLOW_MS);
   localparam logic [DWELL_W-1:0] MIN_RP    = DWELL_W'(MIN_PEDGRN_MS);
   localparam logic [DWELL_W-1:0] MIN_RY    = DWELL_W'(MIN_REDYEL_MS);

   logic [4:0]         lamps;
   phase_t             phase, phase_nxt, cand, prev_cand;
   logic [CNT_W-1:0]   run_cnt, run_cnt_nxt;
   logic [PRE_W-1:0]   presc;
   logic [DWELL_W-1:0] dwell;
   logic               accept, legal, too_short, conflict_now, tick;
   logic               conflict_q, seq_q, short_q, toggle_q;

   // Register the lamp pins once: {RR, RY, RG, PR, PG}
   always_ff @(posedge CLK_PCB) begin
      if (nRST_PCB) lamps <= '0;
      else          lamps <= {ROAD_RED, ROAD_YELLOW, ROAD_GREEN, PED_RED, PED_GREEN};
   end

   // Decode the registered lamp pattern into a candidate phase
   always_comb begin
      cand = PH_INVALID;
      unique case (lamps)
         5'b00110: cand = PH_GREEN;
         5'b01010: cand = PH_YELLOW;
         5'b10001: cand = PH_RED_PED;
         5'b11010: cand = PH_RED_YELLOW;
         default:  cand = PH_INVALID;
      endcase
   end

   // Glitch filter, order legality and short-dwell check for the next phase
   always_comb begin
      phase_nxt   = phase;
      run_cnt_nxt = '0;
      accept      = 1'b0;
      legal       = 1'b0;
      too_short   = 1'b0;
      if (cand != phase) begin
         // a candidate differing from the previous cycle restarts the run at 1
         if (cand == prev_cand) run_cnt_nxt = run_cnt + CNT_ONE;
         else                   run_cnt_nxt = CNT_ONE;
         if (run_cnt_nxt >= STABLE_N) begin
            accept      = 1'b1;
            phase_nxt   = cand;
            run_cnt_nxt = '0;
         end
      end
      unique case (phase)
         PH_UNKNOWN:    legal = 1'b1;
         PH_GREEN:      legal = (cand == PH_YELLOW);
         PH_YELLOW:     legal = (cand == PH_RED_PED);
         PH_RED_PED:    legal = (cand == PH_RED_YELLOW);
         PH_RED_YELLOW: legal = (cand == PH_GREEN);
         default:       legal = 1'b0;
      endcase
      if (cand == PH_INVALID) legal = 1'b0;
      unique case (phase)
         PH_YELLOW:     too_short = (dwell < MIN_Y);
         PH_RED_PED:    too_short = (dwell < MIN_RP);
         PH_RED_YELLOW: too_short = (dwell < MIN_RY);
         default:       too_short = 1'b0;
      endcase
   end

   // Accepted phase, filter run counter and LED toggle
   always_ff @(posedge CLK_PCB) begin
      if (nRST_PCB) begin
         phase     <= PH_UNKNOWN;
         prev_cand <= PH_UNKNOWN;
         run_cnt   <= '0;
         toggle_q  <= 1'b0;
      end else begin
         phase     <= phase_nxt;
         prev_cand <= cand;
         run_cnt   <= run_cnt_nxt;
         if (accept) toggle_q <= ~toggle_q;
      end
   end

   assign tick = (presc == PRE_LAST);

   // ms prescaler and saturating dwell counter; an accepted change restarts both
   always_ff @(posedge CLK_PCB) begin
      if (nRST_PCB) begin
         presc <= '0;
         dwell <= '0;
      end else if (accept) begin
         presc <= '0;
         dwell <= '0;
      end else begin
         presc <= tick ? '0 : presc + 1'b1;
         if (tick && (dwell != '1)) dwell <= dwell + 1'b1;
      end
   end

   assign conflict_now = lamps[0] & (lamps[2] | lamps[3]);

   // Sticky error flags; a new set wins over a same-cycle clear
   always_ff @(posedge CLK_PCB) begin
      if (nRST_PCB) begin
         conflict_q <= 1'b0;
         seq_q      <= 1'b0;
         short_q    <= 1'b0;
      end else begin
         if (conflict_now)            conflict_q <= 1'b1;
         else if (CLR_ERR)            conflict_q <= 1'b0;
         if (accept && !legal)        seq_q      <= 1'b1;
         else if (CLR_ERR)            seq_q      <= 1'b0;
         if (accept && too_short)     short_q    <= 1'b1;
         else if (CLR_ERR)            short_q    <= 1'b0;
      end
   end

   // conflict bypasses the sticky register so a single-cycle overlap shows at once
   assign ERR_CONFLICT = conflict_q | conflict_now;
   assign ERR_SEQUENCE = seq_q;
   assign ERR_SHORT    = short_q;
   assign STATE_CODE   = phase;
   assign DWELL_MS     = dwell;
   assign LED          = {ERR_CONFLICT, seq_q, short_q, toggle_q};

endmodule

// File: tb/tb_lamp_sequence_monitor.sv
// Directed bench for lamp_sequence_monitor with small timing parameters.
module tb_lamp_sequence_monitor;

   localparam logic [4:0] P_GREEN    = 5'b00110;
   localparam logic [4:0] P_YELLOW   = 5'b01010;
   localparam logic [4:0] P_REDPED   = 5'b10001;
   localparam logic [4:0] P_REDYEL   = 5'b11010;
   localparam logic [4:0] P_GLITCH   = 5'b11110;
   localparam logic [4:0] P_CONFLICT = 5'b00111;

   logic       clk  = 1'b0;
   logic       rst  = 1'b1;
   logic [4:0] pins = '0;
   logic       clr  = 1'b0;
   logic [2:0] state_code;
   logic [3:0] dwell_ms;
   logic       err_conflict, err_sequence, err_short;
   logic [3:0] led;

   int checks = 0;
   int errors = 0;

   lamp_sequence_monitor #(
      .TICK_DIV      (4),
      .STABLE_CYC    (2),
      .MIN_YELLOW_MS (2),
      .MIN_PEDGRN_MS (3),
      .MIN_REDYEL_MS (1),
      .DWELL_W       (4)
   ) dut (
      .CLK_PCB      (clk),
      .nRST_PCB     (rst),
      .ROAD_RED     (pins[4]),
      .ROAD_YELLOW  (pins[3]),
      .ROAD_GREEN   (pins[2]),
      .PED_RED      (pins[1]),
      .PED_GREEN    (pins[0]),
      .CLR_ERR      (clr),
      .STATE_CODE   (state_code),
      .DWELL_MS     (dwell_ms),
      .ERR_CONFLICT (err_conflict),
      .ERR_SEQUENCE (err_sequence),
      .ERR_SHORT    (err_short),
      .LED          (led)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Reset with GREEN on the pins, then wait for GREEN to be accepted
   task automatic restart();
      rst  = 1'b1;
      pins = P_GREEN;
      clr  = 1'b0;
      step(2);
      rst = 1'b0;
      step(3);
   endtask

   initial begin
      // 1: reset state, GREEN latency and dwell rate
      step(2);
      check("rst_state", 32'(state_code), 32'd0);
      check("rst_dwell", 32'(dwell_ms), 32'd0);
      check("rst_led", 32'(led), 32'd0);
      check("rst_errs", 32'({err_conflict, err_sequence, err_short}), 32'd0);
      pins = P_GREEN;
      rst  = 1'b0;
      step(2);
      check("lat_before", 32'(state_code), 32'd0);
      step(1);
      check("lat_green", 32'(state_code), 32'd1);
      check("green_errs", 32'({err_conflict, err_sequence, err_short}), 32'd0);
      check("green_led", 32'(led), 32'd1);
      step(3);
      check("dwell_0", 32'(dwell_ms), 32'd0);
      step(1);
      check("dwell_1", 32'(dwell_ms), 32'd1);
      step(4);
      check("dwell_2", 32'(dwell_ms), 32'd2);

      // 2: full legal cycle with dwells exactly at the minimums
      pins = P_YELLOW;
      step(3);
      check("cyc_yellow", 32'(state_code), 32'd2);
      check("cyc_tog_y", 32'(led[0]), 32'd0);
      step(9);
      pins = P_REDPED;
      step(3);
      check("cyc_redped", 32'(state_code), 32'd3);
      check("cyc_tog_rp", 32'(led[0]), 32'd1);
      step(13);
      pins = P_REDYEL;
      step(3);
      check("cyc_redyel", 32'(state_code), 32'd4);
      check("cyc_tog_ry", 32'(led[0]), 32'd0);
      step(5);
      pins = P_GREEN;
      step(3);
      check("cyc_green", 32'(state_code), 32'd1);
      check("cyc_led", 32'(led), 32'd1);
      check("cyc_errs", 32'({err_conflict, err_sequence, err_short}), 32'd0);

      // 3: one-cycle transition glitch is filtered out
      restart();
      pins = P_GLITCH;
      step(1);
      pins = P_YELLOW;
      step(2);
      check("glitch_hold", 32'(state_code), 32'd1);
      step(1);
      check("glitch_yel", 32'(state_code), 32'd2);
      check("glitch_seq", 32'(err_sequence), 32'd0);
      check("glitch_conf", 32'(err_conflict), 32'd0);

      // 4: single-cycle conflict, clear, and set-beats-clear
      restart();
      pins = P_CONFLICT;
      step(1);
      check("conf_now", 32'(err_conflict), 32'd1);
      check("conf_led3", 32'(led[3]), 32'd1);
      pins = P_GREEN;
      step(4);
      check("conf_sticky", 32'(err_conflict), 32'd1);
      check("conf_state", 32'(state_code), 32'd1);
      clr = 1'b1;
      step(1);
      clr = 1'b0;
      check("conf_clr", 32'(err_conflict), 32'd0);
      pins = P_CONFLICT;
      step(1);
      pins = P_GREEN;
      clr  = 1'b1;
      step(1);
      clr = 1'b0;
      check("conf_set_wins", 32'(err_conflict), 32'd1);
      clr = 1'b1;
      step(1);
      clr = 1'b0;
      check("conf_clr2", 32'(led[3]), 32'd0);

      // 5: illegal order, short yellow, invalid pattern accepted
      restart();
      pins = P_REDPED;
      step(3);
      check("seq_state", 32'(state_code), 32'd3);
      check("seq_err", 32'(err_sequence), 32'd1);
      check("seq_short", 32'(err_short), 32'd0);
      check("seq_led", 32'(led), 32'b0100);
      clr = 1'b1;
      step(1);
      clr = 1'b0;
      check("seq_clr", 32'(err_sequence), 32'd0);
      restart();
      pins = P_YELLOW;
      step(3);
      check("short_yel", 32'(state_code), 32'd2);
      step(1);
      pins = P_REDPED;
      step(3);
      check("short_state", 32'(state_code), 32'd3);
      check("short_err", 32'(err_short), 32'd1);
      check("short_seq", 32'(err_sequence), 32'd0);
      check("short_led", 32'(led), 32'b0011);
      pins = P_GLITCH;
      step(3);
      check("inv_state", 32'(state_code), 32'd7);
      check("inv_seq", 32'(err_sequence), 32'd1);

      // 6: dwell saturation, then reset mid-phase
      restart();
      step(40);
      check("sat_mid", 32'(dwell_ms), 32'd10);
      step(40);
      check("sat_top", 32'(dwell_ms), 32'd15);
      pins = P_CONFLICT;
      step(1);
      check("pre_rst_conf", 32'(err_conflict), 32'd1);
      rst = 1'b1;
      step(1);
      check("mid_rst_state", 32'(state_code), 32'd0);
      check("mid_rst_dwell", 32'(dwell_ms), 32'd0);
      check("mid_rst_errs", 32'({err_conflict, err_sequence, err_short}), 32'd0);
      check("mid_rst_led", 32'(led), 32'd0);
      pins = P_GREEN;
      rst  = 1'b0;
      step(3);
      check("post_rst_state", 32'(state_code), 32'd1);
      check("post_rst_seq", 32'(err_sequence), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
